// File: rtl/pipe_bus_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | pipe_bus_pkg                                                      |
// | Shared bus widths, field offsets, bus layouts and ALU opcode      |
// | bit indices for the ID -> EX -> ME pipeline stages.               |
// | Rev 1.0 - initial release                                         |
// +------------------------------------------------------------------+
package pipe_bus_pkg;

  localparam int ID_EX_W  = 148;
  localparam int EX_ME_W  = 71;
  localparam int ALU_OP_W = 12;

  // ID_to_EX_Bus field offsets (LSB of each field)
  localparam int ID_EX_PC_LSB       = 116;
  localparam int ID_EX_ALU_OP_LSB   = 104;
  localparam int ID_EX_SRC1_LSB     = 72;
  localparam int ID_EX_SRC2_LSB     = 40;
  localparam int ID_EX_MEM_WE_BIT   = 39;
  localparam int ID_EX_RES_MEM_BIT  = 38;
  localparam int ID_EX_GR_WE_BIT    = 37;
  localparam int ID_EX_DEST_LSB     = 32;
  localparam int ID_EX_RKD_LSB      = 0;

  // EX_to_ME_Bus field offsets (LSB of each field)
  localparam int EX_ME_PC_LSB       = 39;
  localparam int EX_ME_RESULT_LSB   = 7;
  localparam int EX_ME_RES_MEM_BIT  = 6;
  localparam int EX_ME_GR_WE_BIT    = 5;
  localparam int EX_ME_DEST_LSB     = 0;

  // One-hot ALU operation bit indices
  localparam int ALU_OP_ADD  = 0;
  localparam int ALU_OP_SUB  = 1;
  localparam int ALU_OP_SLT  = 2;
  localparam int ALU_OP_SLTU = 3;
  localparam int ALU_OP_AND  = 4;
  localparam int ALU_OP_NOR  = 5;
  localparam int ALU_OP_OR   = 6;
  localparam int ALU_OP_XOR  = 7;
  localparam int ALU_OP_SLL  = 8;
  localparam int ALU_OP_SRL  = 9;
  localparam int ALU_OP_SRA  = 10;
  localparam int ALU_OP_LUI  = 11;

  // Field order matches the bit layout, MSB first
  typedef struct packed {
    logic [31:0]         pc;
    logic [ALU_OP_W-1:0] alu_op;
    logic [31:0]         src1;
    logic [31:0]         src2;
    logic                mem_we;
    logic                res_from_mem;
    logic                gr_we;
    logic [4:0]          dest;
    logic [31:0]         rkd_value;
  } id_ex_bus_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] alu_result;
    logic        res_from_mem;
    logic        gr_we;
    logic [4:0]  dest;
  } ex_me_bus_t;

endpackage
`default_nettype wire

// File: rtl/pipe_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | pipe_if                                                           |
// | Valid/allow-in pipeline link carrying a W-bit payload bus.        |
// | master = upstream stage, slave = downstream stage.                |
// | Rev 1.0 - initial release                                         |
// +------------------------------------------------------------------+
interface pipe_if #(
  parameter int W = 1
);
  logic         valid;
  logic         allow_in;
  logic [W-1:0] bus;

  modport master (output valid, output bus, input allow_in);
  modport slave  (input valid, input bus, output allow_in);
endinterface
`default_nettype wire

// File: rtl/ex_unit_alu.sv
`default_nettype none
// +------------------------------------------------------------------+
// | ex_alu                                                            |
// | Combinational 32-bit ALU driven by a one-hot operation vector.    |
// | Rev 1.0 - initial release                                         |
// +------------------------------------------------------------------+
module ex_alu
  import pipe_bus_pkg::*;
(
  input  logic [ALU_OP_W-1:0] alu_op,
  input  logic [31:0]         src1,
  input  logic [31:0]         src2,
  output logic [31:0]         result
);

  logic [4:0] shamt;
  assign shamt = src2[4:0];

  // OR together the result of every selected op; a legal one-hot op selects exactly one
  always_comb begin
    result = '0;
    if (alu_op[ALU_OP_ADD])  result = result | (src1 + src2);
    if (alu_op[ALU_OP_SUB])  result = result | (src1 - src2);
    if (alu_op[ALU_OP_SLT])  result = result | {31'b0, ($signed(src1) < $signed(src2))};
    if (alu_op[ALU_OP_SLTU]) result = result | {31'b0, (src1 < src2)};
    if (alu_op[ALU_OP_AND])  result = result | (src1 & src2);
    if (alu_op[ALU_OP_NOR])  result = result | ~(src1 | src2);
    if (alu_op[ALU_OP_OR])   result = result | (src1 | src2);
    if (alu_op[ALU_OP_XOR])  result = result | (src1 ^ src2);
    if (alu_op[ALU_OP_SLL])  result = result | (src1 << shamt);
    if (alu_op[ALU_OP_SRL])  result = result | (src1 >> shamt);
    if (alu_op[ALU_OP_SRA])  result = result | 32'($signed(src1) >>> shamt);
    if (alu_op[ALU_OP_LUI])  result = result | src2;
  end

endmodule
`default_nettype wire

// File: rtl/ex_unit.sv
`default_nettype none
// +------------------------------------------------------------------+
// | ex_unit                                                           |
// | Execute stage: ID->EX pipeline register, ALU, EX->ME handshake    |
// | and data-SRAM request issued on the EX->ME transfer cycle.        |
// | Rev 1.0 - initial release                                         |
// +------------------------------------------------------------------+
module ex_unit
  import pipe_bus_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  pipe_if.slave       id_ex,     // ID_to_EX_Valid / EX_Allow_in / ID_to_EX_Bus
  pipe_if.master      ex_me,     // EX_to_ME_Valid / ME_Allow_in / EX_to_ME_Bus
  output logic [4:0]  EX_dest,
  output logic        data_sram_en,
  output logic [3:0]  data_sram_we,
  output logic [31:0] data_sram_addr,
  output logic [31:0] data_sram_wdata
);

  id_ex_bus_t  id_bus;
  id_ex_bus_t  payload_q, payload_d;
  ex_me_bus_t  me_bus;
  logic        ex_valid_q, ex_valid_d;
  logic        ex_ready_go;
  logic        ex_allow_in;
  logic        mem_fire;
  logic [31:0] alu_result;

  assign id_bus      = id_ex_bus_t'(id_ex.bus);
  assign ex_ready_go = 1'b1;
  assign ex_allow_in = !ex_valid_q || (ex_ready_go && ex_me.allow_in);

  // Next state: valid follows ID whenever EX can take a new entry; payload only on a real transfer
  always_comb begin
    ex_valid_d = ex_valid_q;
    payload_d  = payload_q;
    if (ex_allow_in) begin
      ex_valid_d = id_ex.valid;
    end
    if (id_ex.valid && ex_allow_in) begin
      payload_d = id_bus;
    end
  end

  // ID->EX pipeline register; reset drops any in-flight instruction
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ex_valid_q <= 1'b0;
      payload_q  <= '0;
    end else begin
      ex_valid_q <= ex_valid_d;
      payload_q  <= payload_d;
    end
  end

  ex_alu u_alu (
    .alu_op (payload_q.alu_op),
    .src1   (payload_q.src1),
    .src2   (payload_q.src2),
    .result (alu_result)
  );

  // Memory request fires only on the cycle the instruction moves into ME,
  // so a stalled access is issued exactly once and load data lines up with ME
  assign mem_fire        = ex_valid_q && ex_me.allow_in;
  assign data_sram_en    = mem_fire && (payload_q.res_from_mem || payload_q.mem_we);
  assign data_sram_we    = {4{mem_fire && payload_q.mem_we}};
  assign data_sram_addr  = alu_result;
  assign data_sram_wdata = payload_q.rkd_value;

  assign me_bus.pc           = payload_q.pc;
  assign me_bus.alu_result   = alu_result;
  assign me_bus.res_from_mem = payload_q.res_from_mem;
  assign me_bus.gr_we        = payload_q.gr_we;
  assign me_bus.dest         = payload_q.dest;

  assign id_ex.allow_in = ex_allow_in;
  assign ex_me.valid    = ex_valid_q && ex_ready_go;
  assign ex_me.bus      = me_bus;
  assign EX_dest        = payload_q.dest & {5{ex_valid_q}};

endmodule
`default_nettype wire
